sd_cmd_sequencer: RTL and testbench

- Sequences the 8-bit SPI byte engine to issue one SD-card SPI-mode command frame.
- Polls for the R1 response, then releases chip select.
- Also issues the power-up preamble: ≥74 clocks with CS high.
- Sits between the SD init/read state machine (requester) and the byte engine.

---
 rtl/sd_cmd_sequencer_if.sv | 31 +++
 rtl/sd_cmd_sequencer.sv | 168 ++++++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sd_cmd_sequencer_if.sv
// Signal bundle between the SD command sequencer, its requester and the SPI byte engine.
// The sequencer uses the slave view; the requester/engine side uses the master view.
interface sd_cmd_sequencer_if;
    logic        cmd_start;
    logic        preamble_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [6:0]  cmd_crc;
    logic        spi_execute;
    logic [7:0]  spi_out_word;
    logic [7:0]  spi_in_word;
    logic        spi_finished;
    logic        spi_busy;
    logic        cs_n;
    logic        busy;
    logic        done;
    logic [7:0]  r1;
    logic        timeout;

    modport slave (
        input  cmd_start, preamble_start, cmd_index, cmd_arg, cmd_crc,
        input  spi_in_word, spi_finished, spi_busy,
        output spi_execute, spi_out_word, cs_n, busy, done, r1, timeout
    );

    modport master (
        output cmd_start, preamble_start, cmd_index, cmd_arg, cmd_crc,
        output spi_in_word, spi_finished, spi_busy,
        input  spi_execute, spi_out_word, cs_n, busy, done, r1, timeout
    );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// Drives the SPI byte engine to send one SD SPI-mode command frame and poll for R1,
// or to clock out the power-up preamble with chip select high.
module sd_cmd_sequencer #(
    parameter int unsigned MAX_POLL       = 8,
    parameter int unsigned PREAMBLE_BYTES = 10
) (
    input logic                 clk,
    input logic                 rst_n,
    sd_cmd_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {StIdle, StPre, StCmd, StPoll, StTrail, StFin} state_e;

    state_e      state_q, state_d;
    logic        wait_q, wait_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  poll_cnt_q, poll_cnt_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic [6:0]  crc_q, crc_d;
    logic        exec_q, exec_d;
    logic [7:0]  out_q, out_d;
    logic        cs_n_q, cs_n_d;
    logic [7:0]  r1_q, r1_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  tx_byte;
    logic        sending;
    logic        fin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wait_q     <= 1'b0;
            byte_cnt_q <= '0;
            poll_cnt_q <= '0;
            idx_q      <= '0;
            arg_q      <= '0;
            crc_q      <= '0;
            exec_q     <= 1'b0;
            out_q      <= 8'hFF;
            cs_n_q     <= 1'b1;
            r1_q       <= 8'hFF;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            byte_cnt_q <= byte_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            idx_q      <= idx_d;
            arg_q      <= arg_d;
            crc_q      <= crc_d;
            exec_q     <= exec_d;
            out_q      <= out_d;
            cs_n_q     <= cs_n_d;
            r1_q       <= r1_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        tx_byte = 8'hFF;
        if (state_q == StCmd) begin
            case (byte_cnt_q)
                8'd0:    tx_byte = {2'b01, idx_q};
                8'd1:    tx_byte = arg_q[31:24];
                8'd2:    tx_byte = arg_q[23:16];
                8'd3:    tx_byte = arg_q[15:8];
                8'd4:    tx_byte = arg_q[7:0];
                default: tx_byte = {crc_q, 1'b1};
            endcase
        end
    end

    assign sending = (state_q == StPre) || (state_q == StCmd) ||
                     (state_q == StPoll) || (state_q == StTrail);
    // wait_q marks a byte in flight: a finish pulse only counts once we have issued one.
    assign fin = sending && wait_q && bus.spi_finished;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        byte_cnt_d = byte_cnt_q;
        poll_cnt_d = poll_cnt_q;
        idx_d      = idx_q;
        arg_d      = arg_q;
        crc_d      = crc_q;
        exec_d     = 1'b0;
        out_d      = out_q;
        cs_n_d     = cs_n_q;
        r1_d       = r1_q;
        timeout_d  = timeout_q;

        if (sending && !wait_q && !bus.spi_busy) begin
            exec_d = 1'b1;
            out_d  = tx_byte;
            wait_d = 1'b1;
        end
        if (fin) begin
            wait_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                wait_d = 1'b0;
                if (bus.preamble_start) begin
                    state_d    = StPre;
                    byte_cnt_d = '0;
                end else if (bus.cmd_start) begin
                    state_d    = StCmd;
                    byte_cnt_d = '0;
                    idx_d      = bus.cmd_index;
                    arg_d      = bus.cmd_arg;
                    crc_d      = bus.cmd_crc;
                    timeout_d  = 1'b0;
                    cs_n_d     = 1'b0;
                end
            end
            StPre: begin
                if (fin) begin
                    if (byte_cnt_q == 8'(PREAMBLE_BYTES - 1)) state_d = StFin;
                    else byte_cnt_d = byte_cnt_q + 8'd1;
                end
            end
            StCmd: begin
                if (fin) begin
                    if (byte_cnt_q == 8'd5) begin
                        state_d    = StPoll;
                        poll_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
            end
            StPoll: begin
                if (fin) begin
                    if (!bus.spi_in_word[7]) begin
                        r1_d    = bus.spi_in_word;
                        state_d = StTrail;
                        cs_n_d  = 1'b1;
                    end else if (poll_cnt_q + 8'd1 == 8'(MAX_POLL)) begin
                        r1_d      = 8'hFF;
                        timeout_d = 1'b1;
                        state_d   = StTrail;
                        cs_n_d    = 1'b1;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 8'd1;
                    end
                end
            end
            StTrail: begin
                if (fin) state_d = StFin;
            end
            StFin: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.spi_execute  = exec_q;
    assign bus.spi_out_word = out_q;
    assign bus.cs_n         = cs_n_q;
    assign bus.busy         = (state_q != StIdle);
    assign bus.done         = (state_q == StFin);
    assign bus.r1           = r1_q;
    assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer: command vectors from a table, plus preamble,
// ignored-request and mid-frame reset sequences, against a simple byte-engine model.
module tb_sd_cmd_sequencer;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [6:0]  crc;
        logic [47:0] frame;
        int          nff;
        logic [7:0]  resp;
        int          polls;
        logic [7:0]  r1;
        logic        to;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    sd_cmd_sequencer_if bus ();

    sd_cmd_sequencer #(.MAX_POLL(8), .PREAMBLE_BYTES(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Byte engine model: 4 clocks per byte, logs every transmitted byte and cs_n.
    logic       eng_busy = 1'b0;
    logic       eng_fin = 1'b0;
    logic [7:0] eng_in = 8'hFF;
    int         eng_cnt = 0;
    int         log_n = 0;
    logic [7:0] log_b [1024];
    logic       log_cs [1024];
    int         cur_base = 0;
    int         cur_nff = 0;
    logic [7:0] cur_resp = 8'hFF;
    int         done_cnt = 0;
    int         cs_low_cnt = 0;
    int         n_checks = 0;
    int         n_err = 0;

    assign bus.spi_busy     = eng_busy;
    assign bus.spi_finished = eng_fin;
    assign bus.spi_in_word  = eng_in;

    function automatic logic [7:0] resp_for(input int pn);
        return (pn == cur_nff + 1) ? cur_resp : 8'hFF;
    endfunction

    always @(posedge clk) begin
        eng_fin <= 1'b0;
        if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                eng_fin  <= 1'b1;
                eng_busy <= 1'b0;
                eng_in   <= resp_for(log_n - cur_base - 6);
            end
        end
        if (bus.spi_execute) begin
            if (log_n < 1024) begin
                log_b[log_n]  <= bus.spi_out_word;
                log_cs[log_n] <= bus.cs_n;
            end
            log_n    <= log_n + 1;
            eng_cnt  <= 4;
            eng_busy <= 1'b1;
        end
        if (bus.done) done_cnt <= done_cnt + 1;
        if (!bus.cs_n) cs_low_cnt <= cs_low_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_done(input int done_base);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done_cnt != done_base) break;
        end
        if (k == 3000) check("done_timeout", 64'(done_cnt - done_base), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame(input vec_t v, input int base, input string tag);
        int n;
        logic [7:0] eb;
        n = 6 + v.polls + 1;
        check({tag, "_nbytes"}, 64'(log_n - base), 64'(n));
        for (int i = 0; i < n && base + i < 1024; i++) begin
            eb = (i < 6) ? v.frame[47 - 8 * i -: 8] : 8'hFF;
            check($sformatf("%s_byte%0d", tag, i), 64'(log_b[base + i]), 64'(eb));
            check($sformatf("%s_cs%0d", tag, i), 64'(log_cs[base + i]), 64'(i == n - 1));
        end
    endtask

    task automatic run_cmd(input vec_t v, input bit inject, input string tag);
        int base;
        int dbase;
        @(negedge clk);
        cur_nff  = v.nff;
        cur_resp = v.resp;
        cur_base = log_n;
        base     = log_n;
        dbase    = done_cnt;
        bus.cmd_index = v.idx;
        bus.cmd_arg   = v.arg;
        bus.cmd_crc   = v.crc;
        bus.cmd_start = 1'b1;
        @(negedge clk);
        bus.cmd_start = 1'b0;
        bus.cmd_index = 6'h3F;
        bus.cmd_arg   = 32'hDEADBEEF;
        bus.cmd_crc   = 7'h11;
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        if (inject) begin
            repeat (20) @(negedge clk);
            bus.cmd_start = 1'b1;
            @(negedge clk);
            bus.cmd_start = 1'b0;
        end
        wait_done(dbase);
        check({tag, "_done_cnt"}, 64'(done_cnt - dbase), 64'd1);
        check({tag, "_r1"}, 64'(bus.r1), 64'(v.r1));
        check({tag, "_timeout"}, 64'(bus.timeout), 64'(v.to));
        check({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_idle_cs"}, 64'(bus.cs_n), 64'd1);
        check_frame(v, base, tag);
    endtask

    task automatic run_pre(input bit both, input logic [7:0] r1_exp, input logic to_exp,
                           input string tag);
        int base;
        int dbase;
        int cbase;
        @(negedge clk);
        base  = log_n;
        dbase = done_cnt;
        cbase = cs_low_cnt;
        bus.preamble_start = 1'b1;
        bus.cmd_start      = both;
        @(negedge clk);
        bus.preamble_start = 1'b0;
        bus.cmd_start      = 1'b0;
        wait_done(dbase);
        check({tag, "_nbytes"}, 64'(log_n - base), 64'd10);
        for (int i = 0; i < 10 && base + i < 1024; i++) begin
            check($sformatf("%s_byte%0d", tag, i), 64'(log_b[base + i]), 64'hFF);
        end
        check({tag, "_cs_low_cycles"}, 64'(cs_low_cnt - cbase), 64'd0);
        check({tag, "_done_cnt"}, 64'(done_cnt - dbase), 64'd1);
        check({tag, "_r1"}, 64'(bus.r1), 64'(r1_exp));
        check({tag, "_timeout"}, 64'(bus.timeout), 64'(to_exp));
    endtask

    vec_t vecs [4];

    initial begin
        int base;
        int k;
        vecs[0] = '{6'd0, 32'h0, 7'h4A, 48'h40_00_00_00_00_95, 2, 8'h01, 3, 8'h01, 1'b0};
        vecs[1] = '{6'd55, 32'h0, 7'h32, 48'h77_00_00_00_00_65, 7, 8'h00, 8, 8'h00, 1'b0};
        vecs[2] = '{6'd41, 32'h4000_0000, 7'h3B, 48'h69_40_00_00_00_77, 0, 8'h05, 1, 8'h05,
                    1'b0};
        vecs[3] = '{6'd8, 32'h0000_01AA, 7'h43, 48'h48_00_00_01_AA_87, 255, 8'hFF, 8, 8'hFF,
                    1'b1};

        bus.cmd_start      = 1'b0;
        bus.preamble_start = 1'b0;
        bus.cmd_index      = '0;
        bus.cmd_arg        = '0;
        bus.cmd_crc        = '0;
        repeat (3) @(negedge clk);
        check("reset_cs_n", 64'(bus.cs_n), 64'd1);
        check("reset_out_word", 64'(bus.spi_out_word), 64'hFF);
        check("reset_r1", 64'(bus.r1), 64'hFF);
        rst_n = 1'b1;

        base = log_n;
        repeat (20) @(negedge clk);
        check("idle_exec_cnt", 64'(log_n - base), 64'd0);
        check("idle_cs_n", 64'(bus.cs_n), 64'd1);
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_done", 64'(bus.done), 64'd0);
        check("idle_r1", 64'(bus.r1), 64'hFF);
        check("idle_timeout", 64'(bus.timeout), 64'd0);

        run_pre(1'b0, 8'hFF, 1'b0, "pre_reset");

        for (int i = 0; i < 4; i++) run_cmd(vecs[i], 1'b0, $sformatf("vec%0d", i));

        run_pre(1'b0, 8'hFF, 1'b1, "pre_after_to");
        run_pre(1'b1, 8'hFF, 1'b1, "pre_both");

        run_cmd(vecs[2], 1'b1, "inject");

        // Reset while command byte 3 is in flight.
        @(negedge clk);
        cur_nff  = vecs[0].nff;
        cur_resp = vecs[0].resp;
        cur_base = log_n;
        base     = log_n;
        bus.cmd_index = vecs[0].idx;
        bus.cmd_arg   = vecs[0].arg;
        bus.cmd_crc   = vecs[0].crc;
        bus.cmd_start = 1'b1;
        @(negedge clk);
        bus.cmd_start = 1'b0;
        for (k = 0; k < 500; k++) begin
            if (log_n - base >= 3) break;
            @(negedge clk);
        end
        check("rst_reach_byte3", 64'(k < 500), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_cs_n", 64'(bus.cs_n), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_out_word", 64'(bus.spi_out_word), 64'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        run_cmd(vecs[0], 1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
